// File: rtl/aha_tlx_hs_pkg.sv
// rtl/aha_tlx_hs_pkg.sv - shared types and constants for the TLX req/ack handshake sender
package aha_tlx_hs_pkg;

    // Sender handshake states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs_state_e;

    // Fewest flops allowed on an asynchronous crossing
    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/aha_tlx_sync_ff.sv
// rtl/aha_tlx_sync_ff.sv - single-bit multi-flop synchronizer, async active-high reset to 0
module aha_tlx_sync_ff
    import aha_tlx_hs_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each clock
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    // Chain flops; every stage clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/aha_tlx_hs_sender.sv
// rtl/aha_tlx_hs_sender.sv - four-phase req/ack CDC sender; optional timeout via AHA_TLX_HS_TIMEOUT_EN
module aha_tlx_hs_sender
    import aha_tlx_hs_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SEND_VALID,
    output logic             SEND_READY,
    input  logic [WIDTH-1:0] SEND_DATA,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             REQ_OUT,
    input  logic             ACK_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("aha_tlx_hs_sender: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    hs_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             ack_s;
    logic             send_ready;

    aha_tlx_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (CLK),
        .rst   (RESET),
        .d_in  (ACK_IN),
        .q_out (ack_s)
    );

    // A new word may only launch from IDLE once the far end has released its ack
    assign send_ready = (state_q == IDLE) && !ack_s;

`ifdef AHA_TLX_HS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic             timeout_q, timeout_d;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cnt_hit = (state_q != IDLE) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

    // Handshake sequencing: launch, wait for ack high, wait for ack low
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        req_d      = req_q;
        done_d     = 1'b0;
`ifdef AHA_TLX_HS_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (SEND_VALID && send_ready) begin
                    data_out_d = SEND_DATA;
                    req_d      = 1'b1;
                    state_d    = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
`ifdef AHA_TLX_HS_TIMEOUT_EN
        // A stalled far end abandons the word; the sticky flag records it
        if (cnt_hit) begin
            req_d     = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
`endif
    end

`ifdef AHA_TLX_HS_TIMEOUT_EN
    // Wait-time counter restarts on every state change and runs only mid-handshake
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_inc;
        end
    end
`endif

    // State and output registers; reset drops REQ immediately and discards the word
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef AHA_TLX_HS_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            req_q      <= req_d;
            done_q     <= done_d;
`ifdef AHA_TLX_HS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign SEND_READY = send_ready;
    assign DATA_OUT   = data_out_q;
    assign REQ_OUT    = req_q;
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
`ifdef AHA_TLX_HS_TIMEOUT_EN
    assign TIMEOUT    = timeout_q;
`else
    assign TIMEOUT    = 1'b0;
`endif

endmodule
